msg_frame_tx: RTL and testbench

Parametrised successor to the OPB trace-message writer. Captures every OPB read/write into a small transaction queue, so back-to-back accesses are not lost. Serialises each transaction into a byte frame for the UART TX FIFO: header, address, data, optional XOR checksum, tail. Sits between the OPB slave interface and msg_buffer's TX FIFO. Adds stall timeout, drop counting and frame-done reporting.

---
 rtl/msg_frame_pkg.sv | 25 ++
 rtl/msg_frame_tx_if.sv | 25 ++
 rtl/msg_txn_queue.sv | 52 +++++
 rtl/msg_frame_tx.sv | 183 ++++++++++++++++++
 tb/tb_msg_frame_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_frame_pkg.sv
// Shared types and constants for the OPB trace-message frame writer.
// The queue entry is sized for the widest bus so one struct serves every width.
package msg_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEAD,
      ADDR,
      DATA,
      CHK,
      TAIL
   } frame_state_t;

   localparam logic [7:0] DEF_HDR_WR  = 8'h5A;
   localparam logic [7:0] DEF_HDR_RD  = 8'h5B;
   localparam logic [7:0] DEF_TAIL_WR = 8'hA5;
   localparam logic [7:0] DEF_TAIL_RD = 8'hA4;

   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

endpackage

// File: rtl/msg_frame_tx_if.sv
// OPB capture side and UART TX FIFO side of the frame writer.
// The slave modport is the frame writer; the master modport is its environment.
interface msg_frame_tx_if #(
   parameter int ADDR_BYTES = 4,
   parameter int DATA_BYTES = 4
);
   logic [8*ADDR_BYTES-1:0] OPB_ADDR;
   logic [8*DATA_BYTES-1:0] OPB_DO;
   logic [8*DATA_BYTES-1:0] OPB_DI;
   logic                    OPB_WE;
   logic                    OPB_RE;
   logic                    TX_FIFO_WR;
   logic [7:0]              TX_FIFO_DATA;
   logic                    TX_FIFO_FULL;

   modport master (
      output OPB_ADDR, OPB_DO, OPB_DI, OPB_WE, OPB_RE, TX_FIFO_FULL,
      input  TX_FIFO_WR, TX_FIFO_DATA
   );

   modport slave (
      input  OPB_ADDR, OPB_DO, OPB_DI, OPB_WE, OPB_RE, TX_FIFO_FULL,
      output TX_FIFO_WR, TX_FIFO_DATA
   );
endinterface

// File: rtl/msg_txn_queue.sv
// Synchronous transaction FIFO. A push on a full queue is still accepted when
// a pop happens in the same cycle, so the slot being freed is reused at once.
module msg_txn_queue
   import msg_frame_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  txn_t                   din,
   output txn_t                   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   txn_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/msg_frame_tx.sv
// Captures OPB accesses into a queue and serialises each one into a byte frame
// (header, address, data, optional XOR checksum, tail) for the UART TX FIFO.
//
// state | meaning
// IDLE  | waiting for a queued transaction; pops it and loads the shifters
// HEAD  | issue header byte (write or read flavour)
// ADDR  | issue address bytes, MSB first
// DATA  | issue data bytes, MSB first
// CHK   | issue XOR of header, address and data bytes
// TAIL  | issue tail byte, then back to IDLE
module msg_frame_tx
   import msg_frame_pkg::*;
#(
   parameter int         ADDR_BYTES    = 4,
   parameter int         DATA_BYTES    = 4,
   parameter int         QDEPTH        = 4,
   parameter bit         CHKSUM_EN     = 1'b1,
   parameter int         TIMEOUT_LIMIT = 200,
   parameter logic [7:0] HDR_WR        = DEF_HDR_WR,
   parameter logic [7:0] HDR_RD        = DEF_HDR_RD,
   parameter logic [7:0] TAIL_WR       = DEF_TAIL_WR,
   parameter logic [7:0] TAIL_RD       = DEF_TAIL_RD
) (
   input  logic                    OPB_CLK,
   input  logic                    OPB_RST,
   input  logic                    PULSE_2KHZ,
   msg_frame_tx_if.slave           bus,
   output logic                    FRAME_DONE,
   output logic                    ERROR_FLAG,
   output logic [15:0]             DROP_CNT,
   output logic [$clog2(QDEPTH):0] Q_LEVEL
);
   localparam int TO_W = $clog2(TIMEOUT_LIMIT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_LIMIT - 1);

   frame_state_t    state, state_d;
   logic [31:0]     sh_addr, sh_addr_d;
   logic [31:0]     sh_data, sh_data_d;
   logic [1:0]      byte_cnt, byte_cnt_d;
   logic [7:0]      chk, chk_d;
   logic            is_wr, is_wr_d;
   logic [TO_W-1:0] to_cnt, to_cnt_d;
   logic [7:0]      cur_byte;
   logic            tx_wr, tx_wr_d;
   logic [7:0]      tx_data, tx_data_d;
   logic            done_d, err_d;

   logic strobe, pop, q_full, q_empty, drop;
   txn_t q_din, q_dout;

   assign strobe = bus.OPB_WE || bus.OPB_RE;
   assign drop   = strobe && q_full && !pop;

   // A simultaneous WE/RE is a write, so WE alone selects the data source.
   always_comb begin
      q_din = '0;
      q_din.is_wr = bus.OPB_WE;
      q_din.addr[8*ADDR_BYTES-1:0] = bus.OPB_ADDR;
      q_din.data[8*DATA_BYTES-1:0] = bus.OPB_WE ? bus.OPB_DO : bus.OPB_DI;
   end

   msg_txn_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk   (OPB_CLK),
      .rst   (OPB_RST),
      .push  (strobe),
      .pop   (pop),
      .din   (q_din),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty),
      .level (Q_LEVEL)
   );

   always_comb begin
      state_d    = state;
      sh_addr_d  = sh_addr;
      sh_data_d  = sh_data;
      byte_cnt_d = byte_cnt;
      chk_d      = chk;
      is_wr_d    = is_wr;
      to_cnt_d   = to_cnt;
      pop        = 1'b0;
      tx_wr_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cur_byte   = 8'h00;

      case (state)
         HEAD:    cur_byte = is_wr ? HDR_WR : HDR_RD;
         ADDR:    cur_byte = sh_addr[31:24];
         DATA:    cur_byte = sh_data[31:24];
         CHK:     cur_byte = chk;
         TAIL:    cur_byte = is_wr ? TAIL_WR : TAIL_RD;
         default: ;
      endcase

      if (state == IDLE) begin
         to_cnt_d = '0;
         if (!q_empty) begin
            pop       = 1'b1;
            // Left-align the fields so every byte leaves from bits [31:24].
            sh_addr_d = q_dout.addr << (8 * (4 - ADDR_BYTES));
            sh_data_d = q_dout.data << (8 * (4 - DATA_BYTES));
            is_wr_d   = q_dout.is_wr;
            chk_d     = 8'h00;
            state_d   = HEAD;
         end
      end else if (!bus.TX_FIFO_FULL) begin
         tx_wr_d  = 1'b1;
         to_cnt_d = '0;
         chk_d    = chk ^ cur_byte;
         case (state)
            HEAD: begin
               state_d    = ADDR;
               byte_cnt_d = 2'(ADDR_BYTES - 1);
            end
            ADDR: begin
               sh_addr_d = sh_addr << 8;
               if (byte_cnt == 2'd0) begin
                  state_d    = DATA;
                  byte_cnt_d = 2'(DATA_BYTES - 1);
               end else begin
                  byte_cnt_d = byte_cnt - 1'b1;
               end
            end
            DATA: begin
               sh_data_d = sh_data << 8;
               if (byte_cnt == 2'd0) state_d = CHKSUM_EN ? CHK : TAIL;
               else                  byte_cnt_d = byte_cnt - 1'b1;
            end
            CHK:  state_d = TAIL;
            TAIL: begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            default: ;
         endcase
      end else if (PULSE_2KHZ) begin
         if (to_cnt == TO_LAST) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_cnt + 1'b1;
         end
      end

      tx_data_d = tx_wr_d ? cur_byte : 8'h00;
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         state      <= IDLE;
         sh_addr    <= '0;
         sh_data    <= '0;
         byte_cnt   <= '0;
         chk        <= '0;
         is_wr      <= 1'b0;
         to_cnt     <= '0;
         tx_wr      <= 1'b0;
         tx_data    <= 8'h00;
         FRAME_DONE <= 1'b0;
         ERROR_FLAG <= 1'b0;
         DROP_CNT   <= 16'h0000;
      end else begin
         state      <= state_d;
         sh_addr    <= sh_addr_d;
         sh_data    <= sh_data_d;
         byte_cnt   <= byte_cnt_d;
         chk        <= chk_d;
         is_wr      <= is_wr_d;
         to_cnt     <= to_cnt_d;
         tx_wr      <= tx_wr_d;
         tx_data    <= tx_data_d;
         FRAME_DONE <= done_d;
         ERROR_FLAG <= err_d;
         if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
      end
   end

   assign bus.TX_FIFO_WR   = tx_wr;
   assign bus.TX_FIFO_DATA = tx_data;
endmodule

// File: tb/tb_msg_frame_tx.sv
// Bench for msg_frame_tx: dut0 has the checksum and a long timeout, dut1 has no
// checksum and a 3-tick timeout. Expected frames come from a byte-list model.
module tb_msg_frame_tx;

   logic        OPB_CLK = 1'b0;
   logic        OPB_RST;
   logic        pulse0, pulse1;
   logic        done0, done1, err0, err1;
   logic [15:0] drop0, drop1;
   logic [2:0]  lvl0, lvl1;

   msg_frame_tx_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) bus0 ();
   msg_frame_tx_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) bus1 ();

   msg_frame_tx #(.QDEPTH(4), .CHKSUM_EN(1'b1), .TIMEOUT_LIMIT(200)) dut0 (
      .OPB_CLK (OPB_CLK), .OPB_RST (OPB_RST), .PULSE_2KHZ (pulse0), .bus (bus0),
      .FRAME_DONE (done0), .ERROR_FLAG (err0), .DROP_CNT (drop0), .Q_LEVEL (lvl0)
   );

   msg_frame_tx #(.QDEPTH(4), .CHKSUM_EN(1'b0), .TIMEOUT_LIMIT(3)) dut1 (
      .OPB_CLK (OPB_CLK), .OPB_RST (OPB_RST), .PULSE_2KHZ (pulse1), .bus (bus1),
      .FRAME_DONE (done1), .ERROR_FLAG (err1), .DROP_CNT (drop1), .Q_LEVEL (lvl1)
   );

   always #5 OPB_CLK = ~OPB_CLK;

   int         cyc = 0;
   int         n_assert = 0;
   int         n_fail = 0;
   int         bad_done = 0;
   int         err0_cnt = 0;
   logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
   int         wr_cyc0[$], done_cyc0[$], done_cyc1[$], err_cyc1[$];
   bit         rnd_stop;

   always @(posedge OPB_CLK) cyc <= cyc + 1;

   always @(negedge OPB_CLK) begin
      if (bus0.TX_FIFO_WR) begin
         got0.push_back(bus0.TX_FIFO_DATA);
         wr_cyc0.push_back(cyc);
      end
      if (bus1.TX_FIFO_WR) got1.push_back(bus1.TX_FIFO_DATA);
      if (done0) begin
         done_cyc0.push_back(cyc);
         if (!bus0.TX_FIFO_WR) bad_done++;
      end
      if (done1) begin
         done_cyc1.push_back(cyc);
         if (!bus1.TX_FIFO_WR) bad_done++;
      end
      if (err0) err0_cnt++;
      if (err1) err_cyc1.push_back(cyc);
   end

   task automatic tick();
      @(negedge OPB_CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input bit we, input bit re,
                        input logic [31:0] a, input logic [31:0] dout, input logic [31:0] din);
      if (d == 0) begin
         bus0.OPB_WE = we; bus0.OPB_RE = re; bus0.OPB_ADDR = a;
         bus0.OPB_DO = dout; bus0.OPB_DI = din;
      end else begin
         bus1.OPB_WE = we; bus1.OPB_RE = re; bus1.OPB_ADDR = a;
         bus1.OPB_DO = dout; bus1.OPB_DI = din;
      end
   endtask

   task automatic clear_strobe(input int d);
      if (d == 0) begin bus0.OPB_WE = 1'b0; bus0.OPB_RE = 1'b0; end
      else        begin bus1.OPB_WE = 1'b0; bus1.OPB_RE = 1'b0; end
   endtask

   // Reference frame: header, 8 field bytes MSB first, XOR (dut0 only), tail.
   task automatic expect_txn(input int d, input bit we, input bit re,
                             input logic [31:0] a, input logic [31:0] dout, input logic [31:0] din);
      logic [7:0]  f[$];
      logic [63:0] body;
      logic [7:0]  x;
      if (!(we || re)) return;
      body = {a, (we ? dout : din)};
      f.push_back(we ? 8'h5A : 8'h5B);
      for (int i = 7; i >= 0; i--) f.push_back(body[8*i +: 8]);
      if (d == 0) begin
         x = 8'h00;
         foreach (f[i]) x ^= f[i];
         f.push_back(x);
      end
      f.push_back(we ? 8'hA5 : 8'hA4);
      foreach (f[i]) begin
         if (d == 0) exp0.push_back(f[i]);
         else        exp1.push_back(f[i]);
      end
   endtask

   task automatic wait_len(input int d, input int n, input int budget, input string name);
      int k = 0;
      while (((d == 0) ? got0.size() : got1.size()) < n && k < budget) begin
         tick();
         k++;
      end
      check({name, " byte budget"}, ((d == 0) ? got0.size() : got1.size()) >= n, 1);
   endtask

   task automatic check_stream(input int d, input string name);
      logic [7:0] g[$], e[$];
      if (d == 0) begin g = got0; e = exp0; end
      else        begin g = got1; e = exp1; end
      check({name, " length"}, g.size(), e.size());
      for (int i = 0; i < e.size(); i++)
         check($sformatf("%s byte%0d", name, i), (i < g.size()) ? {56'd0, g[i]} : 64'hFFFF, {56'd0, e[i]});
   endtask

   task automatic clear_logs();
      got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
      wr_cyc0.delete(); done_cyc0.delete(); done_cyc1.delete(); err_cyc1.delete();
   endtask

   typedef struct {
      bit          we;
      bit          re;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [31:0] din;
      logic [7:0]  hdr;
      logic [7:0]  chk;
      logic [7:0]  tail;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   c0, n;
      vecs[0] = '{1'b1, 1'b0, 32'h12345678, 32'hCAFEBABE, 32'h00000000, 8'h5A, 8'h62, 8'hA5};
      vecs[1] = '{1'b1, 1'b1, 32'h00000000, 32'h01020304, 32'hFFFFFFFF, 8'h5A, 8'h5E, 8'hA5};
      vecs[2] = '{1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'h000000FF, 8'h5B, 8'hB4, 8'hA4};
      vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 8'h5B, 8'h5B, 8'hA4};

      OPB_RST = 1'b1;
      pulse0 = 1'b0; pulse1 = 1'b0;
      drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
      bus0.TX_FIFO_FULL = 1'b0; bus1.TX_FIFO_FULL = 1'b0;
      repeat (3) tick();

      check("reset wr", bus0.TX_FIFO_WR, 0);
      check("reset data", bus0.TX_FIFO_DATA, 0);
      check("reset done/err", {done0, err0, done1, err1}, 0);
      check("reset drop", {drop0, drop1}, 0);
      check("reset level", {lvl0, lvl1}, 0);
      OPB_RST = 1'b0;
      tick();

      // Table: single transactions on dut0, including latency and FRAME_DONE timing.
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         c0 = cyc;
         drive(0, vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].dout, vecs[v].din);
         expect_txn(0, vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].dout, vecs[v].din);
         tick();
         clear_strobe(0);
         check($sformatf("vec%0d level cycle1", v), lvl0, 1);
         wait_len(0, 11, 60, $sformatf("vec%0d", v));
         repeat (4) tick();
         check($sformatf("vec%0d header", v), got0[0], vecs[v].hdr);
         check($sformatf("vec%0d checksum", v), got0[9], vecs[v].chk);
         check($sformatf("vec%0d tail", v), got0[10], vecs[v].tail);
         check($sformatf("vec%0d first wr cycle", v), wr_cyc0[0] - c0, 3);
         check($sformatf("vec%0d last wr cycle", v), wr_cyc0[10] - c0, 13);
         check($sformatf("vec%0d done count", v), done_cyc0.size(), 1);
         check($sformatf("vec%0d done cycle", v), done_cyc0[0] - c0, 13);
         check_stream(0, $sformatf("vec%0d", v));
      end

      // Read without checksum on dut1.
      clear_logs();
      drive(1, 0, 1, 32'h00000010, 32'h0, 32'h000000FF);
      expect_txn(1, 0, 1, 32'h00000010, 32'h0, 32'h000000FF);
      tick();
      clear_strobe(1);
      wait_len(1, 10, 60, "read nochk");
      repeat (4) tick();
      check("read nochk done count", done_cyc1.size(), 1);
      check_stream(1, "read nochk");

      // Six strobes back to back into a depth-4 queue: only the sixth is dropped.
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 0, 32'h1000_0000 + i, 32'h00A0_0000 + i, 32'h0);
         if (i < 5) expect_txn(0, 1, 0, 32'h1000_0000 + i, 32'h00A0_0000 + i, 32'h0);
         tick();
      end
      clear_strobe(0);
      check("burst level", lvl0, 4);
      check("burst drop", drop0, 1);
      wait_len(0, 55, 200, "burst");
      repeat (4) tick();
      check("burst done count", done_cyc0.size(), 5);
      for (int k = 0; k < 4; k++)
         check($sformatf("burst frame gap%0d", k), done_cyc0[k+1] - done_cyc0[k], 12);
      check_stream(0, "burst");

      // FIFO full stall for 20 cycles after the third byte.
      clear_logs();
      drive(0, 1, 0, 32'hABCD0001, 32'h11223344, 32'h0);
      expect_txn(0, 1, 0, 32'hABCD0001, 32'h11223344, 32'h0);
      tick();
      clear_strobe(0);
      wait_len(0, 3, 40, "stall pre");
      bus0.TX_FIFO_FULL = 1'b1;
      n = got0.size();
      repeat (20) tick();
      check("stall no wr", got0.size(), n);
      bus0.TX_FIFO_FULL = 1'b0;
      wait_len(0, 11, 60, "stall post");
      repeat (4) tick();
      check("stall done count", done_cyc0.size(), 1);
      check_stream(0, "stall");

      // Timeout abort on dut1 with FULL held high, then the next queued frame.
      clear_logs();
      bus1.TX_FIFO_FULL = 1'b1;
      drive(1, 1, 0, 32'h0BAD0BAD, 32'h55555555, 32'h0);
      tick();
      drive(1, 0, 1, 32'h00C0FFEE, 32'h0, 32'h87654321);
      expect_txn(1, 0, 1, 32'h00C0FFEE, 32'h0, 32'h87654321);
      tick();
      clear_strobe(1);
      repeat (5) tick();
      for (int k = 1; k <= 3; k++) begin
         repeat (9) tick();
         if (k == 3) check("timeout no early abort", err_cyc1.size(), 0);
         pulse1 = 1'b1;
         tick();
         pulse1 = 1'b0;
      end
      repeat (3) tick();
      check("timeout error pulses", err_cyc1.size(), 1);
      check("timeout no bytes", got1.size(), 0);
      check("timeout no done", done_cyc1.size(), 0);
      check("timeout drop unchanged", drop1, 0);
      check("timeout next popped", lvl1, 0);
      bus1.TX_FIFO_FULL = 1'b0;
      wait_len(1, 10, 60, "after timeout");
      repeat (4) tick();
      check("after timeout done count", done_cyc1.size(), 1);
      check_stream(1, "after timeout");

      // Randomised traffic on dut0 with random FULL back-pressure.
      clear_logs();
      rnd_stop = 1'b0;
      fork
         begin
            while (!rnd_stop) begin
               bus0.TX_FIFO_FULL = ($urandom_range(0, 99) < 35);
               tick();
            end
            bus0.TX_FIFO_FULL = 1'b0;
         end
         begin
            for (int i = 0; i < 30; i++) begin
               int          g;
               bit          we, re;
               logic [31:0] a, dd, di;
               g = 0;
               while (lvl0 >= 3'd4 && g < 500) begin
                  tick();
                  g++;
               end
               we = 1'($urandom_range(0, 1));
               re = we ? 1'($urandom_range(0, 1)) : 1'b1;
               a  = $urandom;
               dd = $urandom;
               di = $urandom;
               drive(0, we, re, a, dd, di);
               expect_txn(0, we, re, a, dd, di);
               tick();
               clear_strobe(0);
               repeat ($urandom_range(0, 3)) tick();
            end
            wait_len(0, 30 * 11, 6000, "random");
            rnd_stop = 1'b1;
         end
      join
      repeat (4) tick();
      check("random done count", done_cyc0.size(), 30);
      check("random drop unchanged", drop0, 1);
      check("random no error", err0_cnt, 0);
      check_stream(0, "random");

      // Reset in the middle of the data bytes, with one more entry queued.
      clear_logs();
      drive(0, 1, 0, 32'h01010101, 32'h7E7E7E7E, 32'h0);
      tick();
      clear_strobe(0);
      tick();
      drive(0, 1, 0, 32'h02020202, 32'h33333333, 32'h0);
      tick();
      clear_strobe(0);
      wait_len(0, 7, 40, "pre reset");
      check("pre reset level", lvl0, 1);
      check("pre reset wr active", bus0.TX_FIFO_WR, 1);
      OPB_RST = 1'b1;
      #1;
      check("reset mid wr", bus0.TX_FIFO_WR, 0);
      check("reset mid data", bus0.TX_FIFO_DATA, 0);
      check("reset mid level", lvl0, 0);
      check("reset mid drop", drop0, 0);
      repeat (3) tick();
      OPB_RST = 1'b0;
      tick();
      clear_logs();
      drive(0, 1, 0, 32'h89ABCDEF, 32'h13579BDF, 32'h0);
      expect_txn(0, 1, 0, 32'h89ABCDEF, 32'h13579BDF, 32'h0);
      tick();
      clear_strobe(0);
      wait_len(0, 11, 60, "post reset");
      repeat (6) tick();
      check("post reset done count", done_cyc0.size(), 1);
      check("post reset level", lvl0, 0);
      check_stream(0, "post reset");

      check("frame done with tail wr", bad_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
